// File: rtl/cla_seq_adder.sv
// cla_seq_adder: nibble-serial CLA add/sub (start/busy/done; in1,in2,c_in,sub -> sum,c_out,p,g,ovf)
module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             p,
  output logic             g,
  output logic             ovf
);
  localparam int NIB = WIDTH / 4;
  localparam int KW = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a, b, acc;
  logic [WIDTH+3:0] cat;
  logic [KW-1:0] k;
  logic cy, p_acc, g_acc, pk, gk, go, last;
  logic [3:0] an, bn, pn, gn, sn;
  logic [4:0] c;
  always_comb begin
    an = a[3:0];
    bn = b[3:0];
    gn = an & bn;
    pn = an ^ bn;
    pk = &pn;
    gk = gn[3] | (pn[3] & gn[2]) | (pn[3] & pn[2] & gn[1]) | (pn[3] & pn[2] & pn[1] & gn[0]);
    c[0] = cy;
    c[1] = gn[0] | (pn[0] & cy);
    c[2] = gn[1] | (pn[1] & gn[0]) | (pn[1] & pn[0] & cy);
    c[3] = gn[2] | (pn[2] & gn[1]) | (pn[2] & pn[1] & gn[0]) | (pn[2] & pn[1] & pn[0] & cy);
    c[4] = gk | (pk & cy);
    sn = pn ^ c[3:0];
    cat = {sn, acc};
    go = start && state != RUN;
    last = k == KW'(NIB - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {a, b, acc, k, cy, p_acc, g_acc} <= '0;
      {busy, done, sum, c_out, p, g, ovf} <= '0;
    end else if (go) begin
      a <= in1;
      b <= sub ? ~in2 : in2;
      cy <= sub ^ c_in;
      p_acc <= 1'b1;
      g_acc <= 1'b0;
      k <= '0;
      state <= RUN;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (state == RUN) begin
      a <= a >> 4;
      b <= b >> 4;
      acc <= cat[WIDTH+3:4];
      cy <= c[4];
      p_acc <= p_acc & pk;
      g_acc <= gk | (pk & g_acc);
      k <= k + 1'b1;
      if (last) begin
        sum <= cat[WIDTH+3:4];
        c_out <= c[4];
        p <= p_acc & pk;
        g <= gk | (pk & g_acc);
        ovf <= c[3] ^ c[4];
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: directed scoreboard bench for the 16-bit nibble-serial adder
module tb_cla_seq_adder;
  logic clk = 0, rst = 1, start = 0, c_in = 0, sub = 0;
  logic [15:0] in1 = 0, in2 = 0;
  logic busy, done, c_out, p, g, ovf;
  logic [15:0] sum;
  logic [19:0] q[$];
  int pass = 0, total = 0, cyc = 0, d1 = 0, d2 = 0, ndone = 0;

  cla_seq_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2), .c_in(c_in), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .p(p), .g(g), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      ndone++;
      d1 = d2;
      d2 = cyc;
      if (q.size() == 0) chk("unexpected_done", 32'(ndone), 32'(0));
      else chk("result{sum,cout,p,g,ovf}", 32'({sum, c_out, p, g, ovf}), 32'(q.pop_front()));
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic s,
                       input logic [15:0] es, input logic eco, input logic ep, input logic eg, input logic eov);
    @(posedge clk); #1;
    in1 = a; in2 = b; c_in = ci; sub = s; start = 1;
    q.push_back({es, eco, ep, eg, eov});
    @(posedge clk); #1;
    start = 0; in1 = 16'hDEAD; in2 = 16'hBEEF; c_in = ~ci; sub = ~s;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", 32'(done), 32'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({busy, done, sum, c_out, p, g, ovf}), 32'(0));
    rst = 0;
    issue(16'h0004, 16'h0004, 0, 0, 16'h0008, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("busy_window{busy,done}", 32'({busy, done}), 32'(2'b10));
      @(posedge clk); #1;
    end
    chk("done_cycle5{busy,done}", 32'({busy, done}), 32'(2'b01));
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'(0));
    issue(16'hFFFF, 16'h0000, 1, 0, 16'h0000, 1, 1, 0, 0); wait_done();
    issue(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 0, 0, 1); wait_done();
    issue(16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0, 0, 0); wait_done();
    issue(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 0, 1, 1); wait_done();
    issue(16'hFFFF, 16'hFFFF, 0, 0, 16'hFFFE, 1, 0, 1, 0); wait_done();
    issue(16'hAAAA, 16'h5555, 0, 0, 16'hFFFF, 0, 1, 0, 0); wait_done();
    repeat (3) @(posedge clk);
    #1;
    chk("hold_sum", 32'({sum, c_out, p}), 32'({16'hFFFF, 1'b0, 1'b1}));
    issue(16'h1111, 16'h2222, 0, 0, 16'h3333, 0, 0, 0, 0);
    @(posedge clk); #1;
    in1 = 16'hFFFF; in2 = 16'hFFFF; c_in = 1; sub = 0; start = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    chk("b2b_first_done", 32'(done), 32'(1));
    in1 = 16'h00FF; in2 = 16'h0F0F; c_in = 0; sub = 0; start = 1;
    q.push_back({16'h100E, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    start = 0;
    wait_done();
    chk("b2b_gap", 32'(d2 - d1), 32'(5));
    issue(16'hAAAA, 16'h1111, 0, 0, 16'hBBBB, 0, 0, 0, 0);
    void'(q.pop_back());
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort{busy,done,sum}", 32'({busy, done, sum}), 32'(0));
    repeat (8) @(posedge clk);
    #1;
    chk("abort_idle_busy", 32'(busy), 32'(0));
    issue(16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, 0, 0); wait_done();
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
